// File: rtl/nfa_stream_ctrl.sv
// Stream sequencer for a bank of regex NFA engines behind a shared char-class
// decoder: forwards bytes, frames each packet with sod/en, reports one match vector.
module nfa_stream_ctrl #(
  parameter int NUM_ENG = 8,
  parameter int DEC_LAT = 1,
  parameter int DRAIN   = 2,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic [7:0]         dec_byte,
  output logic               dec_valid,
  output logic               eng_sod,
  output logic               eng_en,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [NUM_ENG-1:0] m_match,
  output logic               m_any,
  output logic [LEN_W-1:0]   m_len,
  output logic               m_ovf,
  output logic               busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOD    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DEC_LAT + DRAIN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [LEN_W-1:0] len_r;
  logic             ovf_r;
  logic [3:0]       drain_r;
  logic             en_raw_s;
  logic             in_hs_s, out_hs_s;

  assign in_hs_s  = s_valid & s_ready;
  assign out_hs_s = m_valid & m_ready;
  assign s_ready  = (state_r == ST_STREAM);
  assign busy     = (state_r != ST_IDLE);
  // Any controller reset also clears the engines, even mid-packet.
  assign eng_sod  = ~rst | (state_r == ST_SOD);
  assign eng_en   = en_raw_s & ~eng_sod;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (s_valid) state_nxt_s = ST_SOD;
        else         state_nxt_s = ST_IDLE;
      end
      ST_SOD: state_nxt_s = ST_STREAM;
      ST_STREAM: begin
        if (in_hs_s && s_last) state_nxt_s = ST_DRAIN;
        else                   state_nxt_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (drain_r == 4'd1) state_nxt_s = ST_REPORT;
        else                 state_nxt_s = ST_DRAIN;
      end
      ST_REPORT: begin
        if (out_hs_s && s_valid) state_nxt_s = ST_SOD;
        else if (out_hs_s)       state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_REPORT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Decoder feed, length/overflow tracking, drain timing and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_byte  <= 8'd0;
      dec_valid <= 1'b0;
      len_r     <= '0;
      ovf_r     <= 1'b0;
      drain_r   <= 4'd0;
      m_valid   <= 1'b0;
      m_match   <= '0;
      m_any     <= 1'b0;
      m_len     <= '0;
      m_ovf     <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      case (state_r)
        ST_SOD: begin
          len_r <= '0;
          ovf_r <= 1'b0;
        end
        ST_STREAM: begin
          if (in_hs_s) begin
            dec_byte  <= s_data;
            dec_valid <= 1'b1;
            if (len_r == LEN_MAX) ovf_r <= 1'b1;
            else                  len_r <= len_r + LEN_ONE;
            if (s_last) drain_r <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // The engines have settled by the time the count reaches 1.
          if (drain_r == 4'd1) begin
            m_match <= eng_match;
            m_any   <= |eng_match;
            m_len   <= len_r;
            m_ovf   <= ovf_r;
            m_valid <= 1'b1;
          end else begin
            drain_r <= drain_r - 4'd1;
          end
        end
        ST_REPORT: begin
          if (out_hs_s) m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // en follows dec_valid by the decoder latency so each step sees its own byte's classes.
  generate
    if (DEC_LAT == 0) begin : g_en_wire
      assign en_raw_s = dec_valid;
    end else begin : g_en_line
      logic [DEC_LAT-1:0] en_line_r;
      // Enable alignment shift register.
      always_ff @(posedge clk) begin
        if (!rst) begin
          en_line_r <= '0;
        end else begin
          en_line_r[0] <= dec_valid;
          for (int i = 1; i < DEC_LAT; i++) en_line_r[i] <= en_line_r[i-1];
        end
      end
      assign en_raw_s = en_line_r[DEC_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_nfa_stream_ctrl.sv
// Bench for nfa_stream_ctrl: a streaming engine stub feeds the DUT, and results
// are compared against substring searches over each packet's bytes.
module tb_nfa_stream_ctrl;

  logic       clk;
  logic       rst, s_valid, s_last, m_ready;
  logic [7:0] s_data;
  logic       s_ready, dec_valid, eng_sod, eng_en, m_valid, m_any, m_ovf, busy;
  logic [7:0] dec_byte, eng_match, m_match;
  logic [15:0] m_len;
  logic       sat_s_ready, sat_dec_valid, sat_eng_sod, sat_eng_en, sat_m_valid, sat_m_any, sat_m_ovf, sat_busy;
  logic [7:0] sat_dec_byte, sat_m_match;
  logic [3:0] sat_m_len;

  nfa_stream_ctrl #(.NUM_ENG(8), .DEC_LAT(1), .DRAIN(2), .LEN_W(16)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .dec_byte(dec_byte), .dec_valid(dec_valid), .eng_sod(eng_sod), .eng_en(eng_en), .eng_match(eng_match),
    .m_valid(m_valid), .m_ready(m_ready), .m_match(m_match), .m_any(m_any), .m_len(m_len),
    .m_ovf(m_ovf), .busy(busy));

  nfa_stream_ctrl #(.NUM_ENG(8), .DEC_LAT(1), .DRAIN(2), .LEN_W(4)) u_sat (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data), .s_last(s_last),
    .dec_byte(sat_dec_byte), .dec_valid(sat_dec_valid), .eng_sod(sat_eng_sod), .eng_en(sat_eng_en),
    .eng_match(eng_match), .m_valid(sat_m_valid), .m_ready(m_ready), .m_match(sat_m_match),
    .m_any(sat_m_any), .m_len(sat_m_len), .m_ovf(sat_m_ovf), .busy(sat_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string pats [8] = '{"aa", "bb", "cc", "cba", "acb", "baa", "gumblar", "ca"};

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pkt [64];
  int pkt_n;
  logic [7:0] nxt [64];
  int nxt_n;

  // Engine stub: one-cycle decoder, then engines that watch a byte history.
  logic [7:0]  dec_q;
  logic [63:0] hist;

  function automatic bit tail_hit(input logic [63:0] h, input int e);
    int l = pats[e].len();
    for (int k = 0; k < l; k++)
      if (h[8*k +: 8] != pats[e][l-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    dec_q <= dec_byte;
    if (eng_sod) begin
      hist      <= '0;
      eng_match <= '0;
    end else if (eng_en) begin
      hist <= {hist[55:0], dec_q};
      for (int e = 0; e < 8; e++)
        if (tail_hit({hist[55:0], dec_q}, e)) eng_match[e] <= 1'b1;
    end
  end

  // Enable activity per packet plus lockstep comparison of the two instances.
  int cyc = 0, en_cnt = 0, en_first = -1, en_last = -1, viol = 0, ls_diff = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (eng_en && eng_sod) viol <= viol + 1;
    if ({s_ready, dec_valid, dec_byte, eng_sod, eng_en, busy, m_valid, m_any} !==
        {sat_s_ready, sat_dec_valid, sat_dec_byte, sat_eng_sod, sat_eng_en, sat_busy, sat_m_valid, sat_m_any})
      ls_diff <= ls_diff + 1;
    if (eng_sod) begin
      en_cnt <= 0; en_first <= -1; en_last <= -1;
    end else if (eng_en) begin
      en_cnt <= en_cnt + 1;
      if (en_first < 0) en_first <= cyc;
      en_last <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    pkt_n = s.len();
    for (int i = 0; i < pkt_n; i++) pkt[i] = s[i];
  endtask

  function automatic logic [7:0] ref_match();
    logic [7:0] r = 8'h00;
    for (int e = 0; e < 8; e++) begin
      int l = pats[e].len();
      for (int st = 0; st + l <= pkt_n; st++) begin
        bit hit = 1'b1;
        for (int k = 0; k < l; k++)
          if (pkt[st+k] != pats[e][k]) hit = 1'b0;
        if (hit) r[e] = 1'b1;
      end
    end
    return r;
  endfunction

  // Streams pkt; optional stall after byte gap_at; optional reset after byte abort_at.
  task automatic send_pkt(input int gap_at, input int gap_len, input int abort_at);
    int idx = 0;
    int guard = 0;
    bit hs;
    s_valid = 1'b1; s_data = pkt[0]; s_last = (pkt_n == 1);
    while (idx < pkt_n && guard < 500) begin
      @(negedge clk); hs = s_valid && s_ready;
      @(posedge clk); #1; guard++;
      if (hs) begin
        idx++;
        if (idx == abort_at) begin
          rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
          break;
        end
        if (gap_at > 0 && idx == gap_at) begin
          s_valid = 1'b0; s_last = 1'b0;
          repeat (gap_len) @(posedge clk);
          #1;
        end
        if (idx < pkt_n) begin
          s_valid = 1'b1; s_data = pkt[idx]; s_last = (idx == pkt_n - 1);
        end else begin
          s_valid = 1'b0; s_last = 1'b0;
        end
      end
    end
    check("bytes_sent", idx, (abort_at > 0) ? abort_at : pkt_n);
  endtask

  // Waits for the result, checks it, applies backpressure, then accepts it.
  task automatic get_result(input int gap, input int hold, input bit b2b, input logic [7:0] nb, input bit nl);
    logic [7:0] exp_m = ref_match();
    int lat = 0;
    int exp_sat = (pkt_n > 15) ? 15 : pkt_n;
    do begin @(negedge clk); lat++; end while (!m_valid && lat < 60);
    check("latency", lat, 5);
    check("m_valid", m_valid, 1);
    check("m_match", m_match, exp_m);
    check("m_any", m_any, (exp_m != 8'h00));
    check("m_len", m_len, pkt_n);
    check("m_ovf", m_ovf, 0);
    check("sat_m_match", sat_m_match, exp_m);
    check("sat_m_len", sat_m_len, exp_sat);
    check("sat_m_ovf", sat_m_ovf, (pkt_n > 15));
    check("en_count", en_cnt, pkt_n);
    check("en_gap", en_last - en_first + 1 - en_cnt, gap);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", m_valid, 1);
      check("hold_match", m_match, exp_m);
      check("hold_len", m_len, pkt_n);
      check("hold_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    if (b2b) begin s_valid = 1'b1; s_data = nb; s_last = nl; end
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("m_valid_drop", m_valid, 0);
    check("m_match_kept", m_match, exp_m);
    if (b2b) check("b2b_sod", {eng_sod, s_ready}, 2'b10);
    else     check("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int gap_at, gap_len;
    bit b2b;
    rst = 1'b0; m_ready = 1'b0; s_last = 1'b0; s_valid = 1'b1;
    load_str("/gumblar.cn/rss/?id=7");
    s_data = pkt[0];

    repeat (3) begin
      @(negedge clk);
      check("rst_sod", eng_sod, 1);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_eng_en", eng_en, 0);
      check("rst_busy", busy, 0);
      check("rst_m_len", m_len, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_sod", {eng_sod, busy}, 2'b00);
    @(negedge clk);
    check("sod_cycle", {eng_sod, s_ready, eng_en, busy}, 4'b1001);
    @(posedge clk); #1;
    check("after_sod", {eng_sod, s_ready}, 2'b01);

    send_pkt(0, 0, 0);
    get_result(0, 10, 1'b1, 8'h61, 1'b0);
    load_str("abc");
    send_pkt(0, 0, 0);
    get_result(0, 0, 1'b0, 8'h00, 1'b0);

    load_str("/gumblar.cn/rss/?id=7");
    send_pkt(8, 3, 0);
    get_result(3, 2, 1'b0, 8'h00, 1'b0);

    load_str("abcabcabcabcabcabcab");
    send_pkt(0, 0, 0);
    get_result(0, 1, 1'b1, 8'h61, 1'b0);
    load_str("ab");
    send_pkt(0, 0, 0);
    get_result(0, 0, 1'b0, 8'h00, 1'b0);

    load_str("c");
    send_pkt(0, 0, 0);
    get_result(0, 0, 1'b0, 8'h00, 1'b0);

    load_str("/gumblar.cn/rss/?id=7");
    send_pkt(0, 0, 10);
    @(negedge clk);
    check("midrst_sod", {eng_sod, eng_en}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_state", {busy, m_valid, s_ready, eng_en}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    load_str("abc");
    send_pkt(0, 0, 0);
    get_result(0, 0, 1'b0, 8'h00, 1'b0);

    pkt_n = $urandom_range(1, 20);
    for (int i = 0; i < pkt_n; i++) pkt[i] = 8'h61 + 8'($urandom_range(0, 2));
    for (int r = 0; r < 10; r++) begin
      if (pkt_n >= 2 && $urandom_range(0, 1) == 1) begin
        gap_at = $urandom_range(1, pkt_n - 1); gap_len = $urandom_range(1, 3);
      end else begin
        gap_at = 0; gap_len = 0;
      end
      send_pkt(gap_at, gap_len, 0);
      nxt_n = $urandom_range(1, 20);
      for (int i = 0; i < nxt_n; i++) nxt[i] = 8'h61 + 8'($urandom_range(0, 2));
      b2b = (r < 9) && ($urandom_range(0, 1) == 1);
      get_result(gap_len, $urandom_range(0, 3), b2b, nxt[0], (nxt_n == 1));
      pkt_n = nxt_n;
      for (int i = 0; i < nxt_n; i++) pkt[i] = nxt[i];
    end

    check("sod_en_overlap", viol, 0);
    check("lockstep", ls_diff, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
